bp_cce_dir_sharers_collect: RTL and testbench

BP_CCE_DIR_SHARERS_COLLECT -- requirements
Module: bp_cce_dir_sharers_collect

---
 rtl/bp_cce_dir_sharers_collect.sv | 188 ++++++++++++++++++
 tb/tb_bp_cce_dir_sharers_collect.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_dir_sharers_collect.sv
// CCE directory sharer collection: walks the directory rows of one set and gathers per-LCE hits plus
// the requestor's LRU entry. Define BP_CCE_DIR_COLLECT_ASSERT_EN to compile simulation-only checks.

package bp_cce_dir_coh_pkg;
   typedef enum logic [2:0] {
      e_COH_I = 3'b000,
      e_COH_S = 3'b001,
      e_COH_E = 3'b010,
      e_COH_F = 3'b011,
      e_COH_M = 3'b110,
      e_COH_O = 3'b111
   } bp_coh_states_e;
endpackage

module bp_cce_dir_sharers_collect
   import bp_cce_dir_coh_pkg::*;
   #(parameter int num_lce_p          = 1
    ,parameter int lce_assoc_p        = 1
    ,parameter int tag_width_p        = 1
    ,parameter int tag_sets_per_row_p = 2
    ,localparam int s_lp               = $bits(bp_coh_states_e)
    ,localparam int e_lp               = tag_width_p + s_lp
    ,localparam int rows_per_set_lp    = (num_lce_p == 1) ? 1
                                         : (num_lce_p + tag_sets_per_row_p - 1) / tag_sets_per_row_p
    ,localparam int lg_num_lce_lp      = (num_lce_p == 1) ? 1 : $clog2(num_lce_p)
    ,localparam int lg_lce_assoc_lp    = (lce_assoc_p == 1) ? 1 : $clog2(lce_assoc_p)
    ,localparam int lg_rows_per_set_lp = (rows_per_set_lp == 1) ? 1 : $clog2(rows_per_set_lp)
    ,localparam int row_width_lp       = tag_sets_per_row_p * lce_assoc_p * e_lp
    )
   (input  logic                                 clk_i
   ,input  logic                                 reset_i
   ,input  logic                                 start_i
   ,input  logic [tag_width_p-1:0]               tag_i
   ,input  logic [lg_num_lce_lp-1:0]             lce_i
   ,input  logic [lg_lce_assoc_lp-1:0]           lru_way_i
   ,input  logic                                 row_v_i
   ,input  logic [row_width_lp-1:0]              row_i
   ,input  logic                                 clear_i
   ,output logic                                 busy_o
   ,output logic                                 sharers_v_o
   ,output logic [num_lce_p-1:0]                 sharers_hits_o
   ,output logic [num_lce_p*lg_lce_assoc_lp-1:0] sharers_ways_o
   ,output logic [num_lce_p*s_lp-1:0]            sharers_coh_states_o
   ,output logic                                 lru_v_o
   ,output logic                                 lru_cached_excl_o
   ,output logic [tag_width_p-1:0]               lru_tag_o
   );

   typedef enum logic [1:0] {e_IDLE, e_COLLECT, e_DONE} state_e;
   state_e state_q, state_n;

   logic [tag_width_p-1:0]               tag_q;
   logic [lg_num_lce_lp-1:0]             lce_q;
   logic [lg_lce_assoc_lp-1:0]           lru_way_q;
   logic [lg_rows_per_set_lp-1:0]        row_cnt_q;
   logic [num_lce_p-1:0]                 hits_q;
   logic [num_lce_p*lg_lce_assoc_lp-1:0] ways_q;
   logic [num_lce_p*s_lp-1:0]            states_q;
   logic                                 lru_excl_q;
   logic [tag_width_p-1:0]               lru_tag_q;

   logic                       last_row, row_fire;
   logic [num_lce_p-1:0]       row_hit, row_multi;
   logic [lg_lce_assoc_lp-1:0] row_way   [num_lce_p];
   logic [s_lp-1:0]            row_state [num_lce_p];
   logic [e_lp-1:0]            entry;
   logic                       lru_sel, lru_excl_n;
   logic [tag_width_p-1:0]     lru_tag_n;

   assign last_row = (int'(row_cnt_q) == rows_per_set_lp - 1);
   assign row_fire = (state_q == e_COLLECT) && row_v_i;

   // Per-LCE decode of the current row; ways are scanned high to low so the lowest matching way wins.
   always_comb begin
      row_hit    = '0;
      row_multi  = '0;
      entry      = '0;
      lru_sel    = 1'b0;
      lru_excl_n = 1'b0;
      lru_tag_n  = '0;
      for (int l = 0; l < num_lce_p; l++) begin
         row_way[l]   = '0;
         row_state[l] = '0;
         if ((l / tag_sets_per_row_p) == int'(row_cnt_q)) begin
            for (int w = lce_assoc_p - 1; w >= 0; w--) begin
               entry = row_i[((l % tag_sets_per_row_p) * lce_assoc_p + w) * e_lp +: e_lp];
               if ((entry[e_lp-1:s_lp] == tag_q) && (entry[s_lp-1:0] != e_COH_I)) begin
                  row_multi[l] = row_multi[l] | row_hit[l];
                  row_hit[l]   = 1'b1;
                  row_way[l]   = lg_lce_assoc_lp'(w);
                  row_state[l] = entry[s_lp-1:0];
               end
               if ((l == int'(lce_q)) && (w == int'(lru_way_q))) begin
                  lru_sel    = 1'b1;
                  lru_tag_n  = entry[e_lp-1:s_lp];
                  lru_excl_n = (entry[s_lp-1:0] == e_COH_E) || (entry[s_lp-1:0] == e_COH_M);
               end
            end
         end
      end
   end

   always_comb begin
      state_n = state_q;
      if (start_i) begin
         state_n = e_COLLECT;
      end else begin
         case (state_q)
            e_COLLECT: if (row_v_i && last_row) state_n = e_DONE;
            e_DONE:    if (clear_i) state_n = e_IDLE;
            default:   state_n = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= e_IDLE;
      else         state_q <= state_n;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tag_q      <= '0;
         lce_q      <= '0;
         lru_way_q  <= '0;
         row_cnt_q  <= '0;
         hits_q     <= '0;
         ways_q     <= '0;
         states_q   <= '0;
         lru_excl_q <= 1'b0;
         lru_tag_q  <= '0;
      end else if (start_i) begin
         tag_q      <= tag_i;
         lce_q      <= lce_i;
         lru_way_q  <= lru_way_i;
         row_cnt_q  <= '0;
         hits_q     <= '0;
         ways_q     <= '0;
         states_q   <= '0;
         lru_excl_q <= 1'b0;
         lru_tag_q  <= '0;
      end else if (row_fire) begin
         for (int l = 0; l < num_lce_p; l++) begin
            if (row_hit[l]) begin
               hits_q[l]                                        <= 1'b1;
               ways_q[l*lg_lce_assoc_lp +: lg_lce_assoc_lp] <= row_way[l];
               states_q[l*s_lp +: s_lp]                         <= row_state[l];
            end
         end
         if (lru_sel) begin
            lru_tag_q  <= lru_tag_n;
            lru_excl_q <= lru_excl_n;
         end
         // The counter stops on the last row; leaving COLLECT is what ends the collection.
         if (!last_row) row_cnt_q <= row_cnt_q + lg_rows_per_set_lp'(1);
      end
   end

   assign busy_o               = (state_q == e_COLLECT);
   assign sharers_v_o          = (state_q == e_DONE);
   assign lru_v_o              = (state_q == e_DONE);
   assign sharers_hits_o       = hits_q;
   assign sharers_ways_o       = ways_q;
   assign sharers_coh_states_o = states_q;
   assign lru_cached_excl_o    = lru_excl_q;
   assign lru_tag_o            = lru_tag_q;

   // Padding tag sets of the last row never map to an LCE.
   logic unused_row;
   assign unused_row = ^row_i;

`ifdef BP_CCE_DIR_COLLECT_ASSERT_EN
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (row_v_i && (state_q != e_COLLECT))
            $error("bp_cce_dir_sharers_collect: row_v_i outside COLLECT");
         if (row_fire && (|row_multi))
            $error("bp_cce_dir_sharers_collect: multiple matching ways for one LCE");
         if (clear_i && (state_q != e_DONE))
            $error("bp_cce_dir_sharers_collect: clear_i outside DONE");
      end
   end
`else
   logic unused_multi;
   assign unused_multi = |row_multi;
`endif

endmodule

// File: tb/tb_bp_cce_dir_sharers_collect.sv
// Self-checking bench for bp_cce_dir_sharers_collect with 3 LCEs, 2 ways, 8-bit tags (2 rows per set).
// Table vectors and random transactions feed a scoreboard queue; hand sequences cover restart/reset/clear.

module tb_bp_cce_dir_sharers_collect;
   import bp_cce_dir_coh_pkg::*;

   localparam int NL    = 3;
   localparam int NA    = 2;
   localparam int TW    = 8;
   localparam int TSR   = 2;
   localparam int S     = 3;
   localparam int E     = TW + S;
   localparam int RW    = TSR * NA * E;
   localparam int RES_W = 24;

   typedef struct packed {
      logic [2:0] hits;
      logic [2:0] ways;
      logic [8:0] states;
      logic [7:0] lru_tag;
      logic       lru_excl;
   } res_t;

   typedef struct {
      logic [7:0]    tag;
      logic [1:0]    lce;
      logic          lru;
      logic [RW-1:0] row0;
      logic [RW-1:0] row1;
      int            gap;
      res_t          exp;
   } vec_t;

   logic          clk, reset, start, row_v, clear;
   logic [7:0]    tag;
   logic [1:0]    lce;
   logic          lru_way;
   logic [RW-1:0] row;
   logic          busy, sharers_v, lru_v, lru_excl;
   logic [2:0]    hits, ways;
   logic [8:0]    states;
   logic [7:0]    lru_tag;

   logic [RES_W-1:0] exp_q[$];
   res_t             last_exp;
   vec_t             vecs[7];
   int               tests = 0;
   int               fails = 0;

   bp_cce_dir_sharers_collect #(
      .num_lce_p(NL), .lce_assoc_p(NA), .tag_width_p(TW), .tag_sets_per_row_p(TSR)
   ) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .tag_i(tag), .lce_i(lce),
      .lru_way_i(lru_way), .row_v_i(row_v), .row_i(row), .clear_i(clear),
      .busy_o(busy), .sharers_v_o(sharers_v), .sharers_hits_o(hits), .sharers_ways_o(ways),
      .sharers_coh_states_o(states), .lru_v_o(lru_v), .lru_cached_excl_o(lru_excl),
      .lru_tag_o(lru_tag)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] put(input logic [RW-1:0] r, input int t, input int w,
                                         input logic [7:0] tg, input bp_coh_states_e st);
      logic [RW-1:0] x;
      x = r;
      x[(t*NA + w)*E +: E] = {tg, st};
      return x;
   endfunction

   function automatic res_t mk(input logic [2:0] h, input logic [2:0] w, input logic [8:0] s,
                               input logic [7:0] lt, input logic x);
      return res_t'({h, w, s, lt, x});
   endfunction

   // reference model: LCE l lives in row l/TSR, tag set l%TSR; first valid matching way wins
   function automatic res_t model(input logic [7:0] tg, input logic [1:0] lc, input logic lw,
                                  input logic [RW-1:0] r0, input logic [RW-1:0] r1);
      res_t          m;
      logic [RW-1:0] rr;
      logic [E-1:0]  ent;
      logic          found;
      m = '0;
      for (int l = 0; l < NL; l++) begin
         rr    = (l / TSR == 0) ? r0 : r1;
         found = 1'b0;
         for (int w = 0; w < NA; w++) begin
            ent = rr[((l % TSR)*NA + w)*E +: E];
            if (!found && ent[E-1:S] == tg && ent[S-1:0] != 3'b000) begin
               found           = 1'b1;
               m.hits[l]       = 1'b1;
               m.ways[l]       = w[0];
               m.states[l*S +: S] = ent[S-1:0];
            end
            if (l == int'(lc) && w == int'(lw)) begin
               m.lru_tag  = ent[E-1:S];
               m.lru_excl = (ent[S-1:0] == 3'b010) || (ent[S-1:0] == 3'b110);
            end
         end
      end
      return m;
   endfunction

   function automatic logic [RW-1:0] rand_row(input logic [7:0] tg);
      logic [RW-1:0] r;
      logic [2:0]    st;
      logic [7:0]    t;
      r = '0;
      for (int k = 0; k < TSR*NA; k++) begin
         case ($urandom_range(0, 5))
            0: st = 3'b000;
            1: st = 3'b001;
            2: st = 3'b010;
            3: st = 3'b011;
            4: st = 3'b110;
            default: st = 3'b111;
         endcase
         t = ($urandom_range(0, 1) == 1) ? tg : 8'($urandom_range(0, 255));
         r[k*E +: E] = {t, st};
      end
      return r;
   endfunction

   task automatic set_vec(input int i, input logic [7:0] tg, input logic [1:0] lc, input logic lw,
                          input logic [RW-1:0] r0, input logic [RW-1:0] r1, input int gap,
                          input res_t e);
      vecs[i].tag  = tg;
      vecs[i].lce  = lc;
      vecs[i].lru  = lw;
      vecs[i].row0 = r0;
      vecs[i].row1 = r1;
      vecs[i].gap  = gap;
      vecs[i].exp  = e;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_sharers_v"}, sharers_v, 0);
      chk({pfx, "_lru_v"}, lru_v, 0);
      chk({pfx, "_hits"}, hits, 0);
      chk({pfx, "_ways"}, ways, 0);
      chk({pfx, "_states"}, states, 0);
      chk({pfx, "_lru_tag"}, lru_tag, 0);
      chk({pfx, "_lru_excl"}, lru_excl, 0);
   endtask

   task automatic chk_res(input string pfx, input res_t e);
      chk({pfx, "_hits"}, hits, e.hits);
      chk({pfx, "_ways"}, ways, e.ways);
      chk({pfx, "_states"}, states, e.states);
      chk({pfx, "_lru_tag"}, lru_tag, e.lru_tag);
      chk({pfx, "_lru_excl"}, lru_excl, e.lru_excl);
   endtask

   // scoreboard: pop the oldest expectation when the DUT presents a result
   task automatic wait_result;
      int cyc;
      cyc = 0;
      while (!sharers_v && cyc < 10) begin
         step;
         cyc++;
      end
      chk("done_latency", cyc, 0);
      if (sharers_v) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got a result, expected none");
         end else begin
            last_exp = res_t'(exp_q.pop_front());
            chk("lru_v_with_sharers_v", lru_v, 1);
            chk("busy_in_done", busy, 0);
            chk_res("result", last_exp);
         end
      end
   endtask

   // driver: start, row0, gap stall cycles with junk on row_i, row1
   task automatic drive_txn(input logic [7:0] tg, input logic [1:0] lc, input logic lw,
                            input logic [RW-1:0] r0, input logic [RW-1:0] r1, input int gap,
                            input res_t e);
      exp_q.push_back(e);
      start = 1'b1; tag = tg; lce = lc; lru_way = lw;
      step;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      row_v = 1'b1; row = r0;
      step;
      row_v = 1'b0; row = ~r0;
      chk("not_done_after_row0", sharers_v, 0);
      for (int g = 0; g < gap; g++) begin
         step;
         chk("stall_busy", busy, 1);
      end
      row_v = 1'b1; row = r1;
      step;
      row_v = 1'b0;
      wait_result;
   endtask

   task automatic hold_and_clear;
      row_v = 1'b1; row = rand_row(last_exp.lru_tag);
      step;
      step;
      row_v = 1'b0;
      chk("hold_sharers_v", sharers_v, 1);
      chk_res("hold", last_exp);
      clear = 1'b1;
      step;
      clear = 1'b0;
      chk("clear_to_idle_v", sharers_v, 0);
      chk("clear_to_idle_busy", busy, 0);
   endtask

   initial begin
      logic [7:0]    rt;
      logic [1:0]    rl;
      logic          rw;
      logic [RW-1:0] r0, r1;
      int            rg;

      reset = 1'b1; start = 1'b0; row_v = 1'b0; clear = 1'b0;
      tag = '0; lce = '0; lru_way = 1'b0; row = '0;
      step;
      step;
      chk_zero("reset");
      reset = 1'b0;
      step;

      set_vec(0, 8'h5A, 2'd1, 1'b1,
              put(put('0, 0, 1, 8'h5A, e_COH_S), 1, 1, 8'h33, e_COH_M),
              put('0, 0, 0, 8'h5A, e_COH_E), 0,
              mk(3'b101, 3'b001, {3'd2, 3'd0, 3'd1}, 8'h33, 1'b1));
      set_vec(1, 8'h5A, 2'd0, 1'b0, put('0, 0, 0, 8'h5A, e_COH_I), '0, 0,
              mk(3'b000, 3'b000, 9'd0, 8'h5A, 1'b0));
      set_vec(2, 8'h5A, 2'd2, 1'b1,
              put(put(put(put('0, 0, 0, 8'h5A, e_COH_S), 0, 1, 8'h5A, e_COH_S),
                      1, 0, 8'h5A, e_COH_I), 1, 1, 8'h5A, e_COH_O),
              put(put('0, 0, 0, 8'h11, e_COH_F), 0, 1, 8'h22, e_COH_E), 0,
              mk(3'b011, 3'b010, {3'd0, 3'd7, 3'd1}, 8'h22, 1'b1));
      set_vec(3, 8'h5A, 2'd2, 1'b0, put('0, 1, 0, 8'h5A, e_COH_F),
              put(put(put('0, 0, 0, 8'h77, e_COH_M), 0, 1, 8'h5A, e_COH_S), 1, 0, 8'h5A, e_COH_M),
              3, mk(3'b110, 3'b100, {3'd1, 3'd3, 3'd0}, 8'h77, 1'b1));
      set_vec(4, 8'hC3, 2'd0, 1'b0,
              put(put('0, 0, 0, 8'hC3, e_COH_E), 1, 1, 8'hC3, e_COH_O),
              put('0, 0, 1, 8'hC3, e_COH_F), 1,
              mk(3'b111, 3'b110, {3'd3, 3'd7, 3'd2}, 8'hC3, 1'b1));
      set_vec(5, 8'h10, 2'd1, 1'b0,
              put(put('0, 1, 0, 8'h44, e_COH_O), 0, 0, 8'h10, e_COH_I),
              put('0, 1, 1, 8'h10, e_COH_S), 0,
              mk(3'b000, 3'b000, 9'd0, 8'h44, 1'b0));
      set_vec(6, 8'h09, 2'd2, 1'b1, put('0, 1, 0, 8'h09, e_COH_E),
              put(put('0, 0, 1, 8'h09, e_COH_M), 0, 0, 8'h09, e_COH_S), 2,
              mk(3'b110, 3'b000, {3'd1, 3'd2, 3'd0}, 8'h09, 1'b1));

      for (int i = 0; i < 7; i++) begin
         drive_txn(vecs[i].tag, vecs[i].lce, vecs[i].lru, vecs[i].row0, vecs[i].row1,
                   vecs[i].gap, vecs[i].exp);
         hold_and_clear;
      end

      for (int i = 0; i < 20; i++) begin
         rt = 8'($urandom_range(0, 255));
         rl = 2'($urandom_range(0, 2));
         rw = 1'($urandom_range(0, 1));
         rg = $urandom_range(0, 2);
         r0 = rand_row(rt);
         r1 = rand_row(rt);
         drive_txn(rt, rl, rw, r0, r1, rg, model(rt, rl, rw, r0, r1));
         hold_and_clear;
      end

      // restart mid-collection: results and the row counter start over
      start = 1'b1; tag = vecs[0].tag; lce = vecs[0].lce; lru_way = vecs[0].lru;
      step;
      start = 1'b0;
      row_v = 1'b1; row = vecs[0].row0;
      step;
      row_v = 1'b0;
      exp_q.push_back(vecs[4].exp);
      start = 1'b1; tag = vecs[4].tag; lce = vecs[4].lce; lru_way = vecs[4].lru;
      step;
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_hits_cleared", hits, 0);
      chk("restart_lru_tag_cleared", lru_tag, 0);
      row_v = 1'b1; row = vecs[4].row0;
      step;
      chk("restart_counter_zero", sharers_v, 0);
      row = vecs[4].row1;
      step;
      row_v = 1'b0;
      wait_result;
      hold_and_clear;

      // reset mid-collection, with a row presented in the reset cycle
      start = 1'b1; tag = vecs[0].tag; lce = vecs[0].lce; lru_way = vecs[0].lru;
      step;
      start = 1'b0;
      row_v = 1'b1; row = vecs[0].row0;
      step;
      reset = 1'b1; row = vecs[0].row1;
      step;
      reset = 1'b0; row_v = 1'b0;
      chk_zero("mid_reset");
      row_v = 1'b1;
      step;
      row_v = 1'b0;
      chk("idle_ignores_row_v", sharers_v, 0);
      chk("idle_ignores_row_busy", busy, 0);

      // start and clear together in DONE: start wins and clears results
      drive_txn(vecs[2].tag, vecs[2].lce, vecs[2].lru, vecs[2].row0, vecs[2].row1, 0, vecs[2].exp);
      exp_q.push_back(vecs[6].exp);
      start = 1'b1; clear = 1'b1; tag = vecs[6].tag; lce = vecs[6].lce; lru_way = vecs[6].lru;
      step;
      start = 1'b0; clear = 1'b0;
      chk("start_clear_busy", busy, 1);
      chk("start_clear_v", sharers_v, 0);
      chk("start_clear_hits", hits, 0);
      chk("start_clear_states", states, 0);
      chk("start_clear_lru_tag", lru_tag, 0);
      row_v = 1'b1; row = vecs[6].row0;
      step;
      row = vecs[6].row1;
      step;
      row_v = 1'b0;
      wait_result;
      hold_and_clear;

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
